// File: rtl/game_pkg.sv
// Shared types and widths for the player motion controller.
package game_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } game_state_t;

  localparam int DIST_W = 10;
  localparam int VEL_W  = 8;
  localparam int SUM_W  = 12;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw pushbutton followed by a rising-edge detector.
// The pulse is one clk wide and is seen by the consumer on the third edge after the press.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/player_motion_ctrl.sv
// Game state machine (menu/play/won/lost) and vertical jump physics for the player.
// Physics step once per game_tick while playing; state changes on any clk.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_HEIGHT = 300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              game_tick,
  input  logic              start_btn,
  input  logic              jump_btn,
  input  logic              win,
  input  logic              dead,
  output logic [DIST_W-1:0] distance,
  output logic              menuScreen,
  output logic              playerWon,
  output logic              playerLost,
  output logic              airborne
);

  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_HEIGHT);
  localparam logic signed [VEL_W-1:0] JUMP_V = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W-1:0] GRAV_V = VEL_W'(GRAVITY);

  game_state_t state;
  game_state_t next_state;

  logic start_edge;
  logic jump_edge;

  logic signed [VEL_W-1:0] velocity;
  logic                    jump_pending;
  logic signed [SUM_W-1:0] sum;
  logic                    enter_play;
  logic                    enter_menu;
  logic                    takeoff;

  btn_sync_edge u_start (
    .clk   (clk),
    .rst   (reset),
    .btn   (start_btn),
    .pulse (start_edge)
  );

  btn_sync_edge u_jump (
    .clk   (clk),
    .rst   (reset),
    .btn   (jump_btn),
    .pulse (jump_edge)
  );

  always_comb begin
    next_state = state;
    case (state)
      MENU: if (start_edge) next_state = PLAY;
      PLAY: begin
        if (dead)     next_state = LOST;
        else if (win) next_state = WON;
      end
      WON:  if (start_edge) next_state = MENU;
      LOST: if (start_edge) next_state = MENU;
      default: next_state = MENU;
    endcase
  end

  // Flags decode next_state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MENU;
      menuScreen <= 1'b1;
      playerWon  <= 1'b0;
      playerLost <= 1'b0;
    end else begin
      state      <= next_state;
      menuScreen <= (next_state == MENU);
      playerWon  <= (next_state == WON);
      playerLost <= (next_state == LOST);
    end
  end

  assign enter_play = (state == MENU) && start_edge;
  assign enter_menu = ((state == WON) || (state == LOST)) && start_edge;
  assign takeoff    = game_tick && !airborne && jump_pending;

  assign sum = $signed({{(SUM_W-DIST_W){1'b0}}, distance})
             + {{(SUM_W-VEL_W){velocity[VEL_W-1]}}, velocity};

  // The apex clamp only applies while rising, so once velocity is zero the
  // player is free to fall away from the ceiling on the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      distance     <= '0;
      velocity     <= '0;
      airborne     <= 1'b0;
      jump_pending <= 1'b0;
    end else if (enter_play || enter_menu) begin
      distance     <= '0;
      velocity     <= '0;
      airborne     <= 1'b0;
      jump_pending <= 1'b0;
    end else if (state == PLAY) begin
      if (takeoff) begin
        velocity     <= JUMP_V;
        airborne     <= 1'b1;
        jump_pending <= 1'b0;
      end else begin
        if (jump_edge && !airborne) jump_pending <= 1'b1;
        if (game_tick && airborne) begin
          if (sum <= $signed(SUM_W'(0))) begin
            distance <= '0;
            velocity <= '0;
            airborne <= 1'b0;
          end else if ((velocity > $signed(VEL_W'(0))) && (sum >= MAX_S)) begin
            distance <= DIST_W'(MAX_HEIGHT);
            velocity <= '0;
          end else begin
            distance <= sum[DIST_W-1:0];
            velocity <= velocity - GRAV_V;
          end
        end
      end
    end
  end

endmodule
